// File: rtl/mem_responder.sv
// mem_responder: DEPTH x 64-bit word memory with pipelined reads, one-cycle writes, saturating
// access counters and a sticky range-error flag. Define MEM_RESP_CLEAR_EN for post-reset zero-fill.
module mem_responder #(
    parameter int unsigned DEPTH        = 64,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_read_en,
    input  logic [63:0] i_read_addr,
    input  logic        i_write_en,
    input  logic [63:0] i_write_addr,
    input  logic [63:0] i_data,
    output logic [63:0] o_data,
    output logic        o_data_valid,
    output logic        o_ready,
    output logic        o_err,
    output logic [31:0] o_rd_count,
    output logic [31:0] o_wr_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StReset, StClear, StReady} state_e;

    state_e                  state_q, state_d;
    logic                    rd_acc, wr_acc;
    logic                    rd_in_range, wr_in_range;
    logic [63:0]             rd_data;
    logic                    mem_we;
    logic [AW-1:0]           mem_waddr;
    logic [63:0]             mem_wdata;
    logic [63:0]             mem_q [DEPTH];
    logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [63:0]             pipe_data_q [READ_LATENCY];
    logic [63:0]             pipe_data_d [READ_LATENCY];
    logic                    err_q, err_d;
    logic [31:0]             rd_cnt_q, rd_cnt_d;
    logic [31:0]             wr_cnt_q, wr_cnt_d;
`ifdef MEM_RESP_CLEAR_EN
    logic [AW-1:0]           clr_addr_q, clr_addr_d;
`endif

    assign o_ready     = (state_q == StReady);
    assign rd_in_range = (i_read_addr < 64'(DEPTH));
    assign wr_in_range = (i_write_addr < 64'(DEPTH));
    assign rd_acc      = i_read_en & o_ready;
    assign wr_acc      = i_write_en & o_ready;

    always_comb begin
        state_d = state_q;
`ifdef MEM_RESP_CLEAR_EN
        clr_addr_d = clr_addr_q;
`endif
        unique case (state_q)
`ifdef MEM_RESP_CLEAR_EN
            // The first edge after release already clears word 0, so exactly DEPTH cycles busy.
            StReset, StClear: begin
                state_d    = StClear;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == AW'(DEPTH - 1)) begin
                    state_d    = StReady;
                    clr_addr_d = '0;
                end
            end
`else
            StReset: state_d = StReady;
            StClear: state_d = StReady;
`endif
            StReady: state_d = StReady;
            default: state_d = StReset;
        endcase
    end

    always_comb begin
        mem_we    = wr_acc & wr_in_range;
        mem_waddr = i_write_addr[AW-1:0];
        mem_wdata = i_data;
`ifdef MEM_RESP_CLEAR_EN
        if (state_q != StReady) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr_q;
            mem_wdata = '0;
        end
`endif
    end

    // Write-first: a same-edge write to the read address forwards the new data.
    always_comb begin
        rd_data = '0;
        if (rd_in_range) begin
            if (wr_acc && (i_write_addr == i_read_addr)) begin
                rd_data = i_data;
            end else begin
                rd_data = mem_q[i_read_addr[AW-1:0]];
            end
        end
    end

    always_comb begin
        pipe_vld_d[0]  = rd_acc;
        pipe_data_d[0] = rd_data;
        for (int i = 1; i < int'(READ_LATENCY); i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_data_d[i] = pipe_data_q[i-1];
        end
        // Last stage is the output register; it holds the previous response between pulses.
        if (!pipe_vld_d[READ_LATENCY-1]) begin
            pipe_data_d[READ_LATENCY-1] = pipe_data_q[READ_LATENCY-1];
        end
    end

    always_comb begin
        err_d    = err_q | (rd_acc & ~rd_in_range) | (wr_acc & ~wr_in_range);
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (rd_acc && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + 32'd1;
        if (wr_acc && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + 32'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StReset;
            pipe_vld_q <= '0;
            for (int i = 0; i < int'(READ_LATENCY); i++) pipe_data_q[i] <= '0;
            err_q      <= 1'b0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
`ifdef MEM_RESP_CLEAR_EN
            clr_addr_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pipe_vld_q <= pipe_vld_d;
            for (int i = 0; i < int'(READ_LATENCY); i++) pipe_data_q[i] <= pipe_data_d[i];
            err_q      <= err_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
`ifdef MEM_RESP_CLEAR_EN
            clr_addr_q <= clr_addr_d;
`endif
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign o_data       = pipe_data_q[READ_LATENCY-1];
    assign o_data_valid = pipe_vld_q[READ_LATENCY-1];
    assign o_err        = err_q;
    assign o_rd_count   = rd_cnt_q;
    assign o_wr_count   = wr_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: a queue-based reference model predicts every output,
// checked each cycle, plus directed sequences with literal expectations.
module tb_mem_responder;

    localparam int DEPTH = 16;
    localparam int LAT   = 3;
`ifdef MEM_RESP_CLEAR_EN
    localparam int  RDY_DLY    = DEPTH;
    localparam bit  CLEAR_MODE = 1'b1;
`else
    localparam int  RDY_DLY    = 1;
    localparam bit  CLEAR_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_en = 1'b0, wr_en = 1'b0;
    logic [63:0] rd_addr = '0, wr_addr = '0, wdata = '0;
    logic [63:0] o_data;
    logic        o_data_valid, o_ready, o_err;
    logic [31:0] o_rd_count, o_wr_count;

    mem_responder #(
        .DEPTH       (DEPTH),
        .READ_LATENCY(LAT)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_read_en   (rd_en),
        .i_read_addr (rd_addr),
        .i_write_en  (wr_en),
        .i_write_addr(wr_addr),
        .i_data      (wdata),
        .o_data      (o_data),
        .o_data_valid(o_data_valid),
        .o_ready     (o_ready),
        .o_err       (o_err),
        .o_rd_count  (o_rd_count),
        .o_wr_count  (o_wr_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: sparse memory image plus a queue of scheduled responses.
    typedef struct {
        int          due;
        logic [63:0] data;
        bit          known;
    } resp_t;

    logic [63:0]     m_mem   [DEPTH];
    bit              m_known [DEPTH];
    resp_t           m_q[$];
    int              edge_n = 0;
    int              since_rel = 0;
    logic [63:0]     m_last = '0;
    bit              m_last_known = 1'b1;
    bit              m_vld = 1'b0;
    bit              m_err = 1'b0;
    longint unsigned m_rd = 0, m_wr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        since_rel    = 0;
        m_last       = '0;
        m_last_known = 1'b1;
        m_vld        = 1'b0;
        m_err        = 1'b0;
        m_rd         = 0;
        m_wr         = 0;
    endtask

    function automatic longint unsigned sat_inc(input longint unsigned v);
        return (v < 64'hFFFF_FFFF) ? v + 1 : v;
    endfunction

    always @(posedge clk) begin
        if (rst_n) begin
            bit rdy;
            rdy = (since_rel >= RDY_DLY);
            if (CLEAR_MODE && since_rel < DEPTH) begin
                m_mem[since_rel]   = '0;
                m_known[since_rel] = 1'b1;
            end
            if (rdy && rd_en) begin
                resp_t r;
                r.due = edge_n + LAT - 1;
                if (rd_addr >= 64'(DEPTH)) begin
                    r.data  = '0;
                    r.known = 1'b1;
                    m_err   = 1'b1;
                end else if (wr_en && wr_addr == rd_addr) begin
                    r.data  = wdata;
                    r.known = 1'b1;
                end else begin
                    r.data  = m_mem[int'(rd_addr[31:0])];
                    r.known = m_known[int'(rd_addr[31:0])];
                end
                m_q.push_back(r);
                m_rd = sat_inc(m_rd);
            end
            if (rdy && wr_en) begin
                if (wr_addr < 64'(DEPTH)) begin
                    m_mem[int'(wr_addr[31:0])]   = wdata;
                    m_known[int'(wr_addr[31:0])] = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
                m_wr = sat_inc(m_wr);
            end
            since_rel++;
            m_vld = 1'b0;
            if (m_q.size() > 0 && m_q[0].due == edge_n) begin
                m_vld        = 1'b1;
                m_last       = m_q[0].data;
                m_last_known = m_q[0].known;
                void'(m_q.pop_front());
            end
            edge_n++;
        end
    end

    // Compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        chk("ready", {63'b0, o_ready}, {63'b0, (rst_n && since_rel >= RDY_DLY)});
        chk("valid", {63'b0, o_data_valid}, {63'b0, m_vld});
        if (m_last_known) chk("data", o_data, m_last);
        chk("err", {63'b0, o_err}, {63'b0, m_err});
        chk("rd_count", {32'b0, o_rd_count}, m_rd);
        chk("wr_count", {32'b0, o_wr_count}, m_wr);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_ready", {63'b0, o_ready}, 64'd0);
        chk("rst_valid", {63'b0, o_data_valid}, 64'd0);
        chk("rst_data", o_data, 64'd0);
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!o_ready && n < DEPTH + 8) begin
            step();
            n++;
        end
        chk("ready_timeout", {63'b0, o_ready}, 64'd1);
    endtask

    function automatic logic [63:0] rand_addr();
        int sel = $urandom_range(0, 99);
        if (sel < 92) return 64'($urandom_range(0, DEPTH - 1));
        if (sel < 97) return 64'($urandom_range(DEPTH, DEPTH + 3));
        return {$urandom, $urandom} | 64'h8000_0000_0000_0000;
    endfunction

    initial begin
        #20_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit forced;
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        model_reset();
        repeat (3) step();
        chk("reset_rd_count", {32'b0, o_rd_count}, 64'd0);
        chk("reset_err", {63'b0, o_err}, 64'd0);
        rst_n = 1'b1;
        wait_ready();

        // Write then read next cycle; response after exactly LAT edges.
        wr_en = 1'b1; wr_addr = 64'd0; wdata = 64'h15;
        step();
        wr_en = 1'b0; rd_en = 1'b1; rd_addr = 64'd0;
        step();
        idle();
        repeat (LAT - 2) step();
        chk("t1_early_valid", {63'b0, o_data_valid}, 64'd0);
        step();
        chk("t1_valid", {63'b0, o_data_valid}, 64'd1);
        chk("t1_data", o_data, 64'h15);
        step();
        chk("t1_hold_valid", {63'b0, o_data_valid}, 64'd0);
        chk("t1_hold_data", o_data, 64'h15);
        chk("t1_rd_count", {32'b0, o_rd_count}, 64'd1);
        chk("t1_wr_count", {32'b0, o_wr_count}, 64'd1);

        // Same-edge write and read of one address returns the new data.
        wr_en = 1'b1; wr_addr = 64'd5; wdata = 64'hDEAD_BEEF;
        rd_en = 1'b1; rd_addr = 64'd5;
        step();
        idle();
        repeat (LAT - 1) step();
        chk("t2_data", o_data, 64'hDEAD_BEEF);

        // Back-to-back reads return in order on consecutive cycles.
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_addr = 64'(i); wdata = 64'(i + 1);
            step();
        end
        idle();
        for (int j = 0; j < LAT + 4; j++) begin
            int k;
            rd_en   = (j < 4);
            rd_addr = 64'(j);
            step();
            k = j - LAT + 1;
            if (k >= 0 && k < 4) begin
                chk("t3_valid", {63'b0, o_data_valid}, 64'd1);
                chk("t3_data", o_data, 64'(k + 1));
            end
        end
        idle();

        // Out-of-range read returns zero, out-of-range write leaves storage alone.
        wr_en = 1'b1; wr_addr = 64'(DEPTH - 1); wdata = 64'h77;
        step();
        rd_en = 1'b1; rd_addr = 64'(DEPTH);
        wr_en = 1'b1; wr_addr = '1; wdata = 64'hBAD;
        step();
        idle();
        repeat (LAT - 1) step();
        chk("t4_valid", {63'b0, o_data_valid}, 64'd1);
        chk("t4_data", o_data, 64'd0);
        chk("t4_err", {63'b0, o_err}, 64'd1);
        rd_en = 1'b1; rd_addr = 64'(DEPTH - 1);
        step();
        idle();
        repeat (LAT - 1) step();
        chk("t4_mem_kept", o_data, 64'h77);
        chk("t4_err_sticky", {63'b0, o_err}, 64'd1);

        // Reset with reads in flight drops them.
        rd_en = 1'b1; rd_addr = 64'd0;
        step();
        rd_addr = 64'd1;
        step();
        idle();
        do_reset(2);
        repeat (LAT + 1) begin
            step();
            chk("t5_no_valid", {63'b0, o_data_valid}, 64'd0);
        end
        wait_ready();
        chk("t5_rd_count", {32'b0, o_rd_count}, 64'd0);
        chk("t5_err", {63'b0, o_err}, 64'd0);
        rd_en = 1'b1; rd_addr = 64'd0;
        step();
        idle();
        repeat (LAT - 1) step();
        chk("t5_mem_after_reset", o_data, CLEAR_MODE ? 64'd0 : 64'd1);

        // Requests before o_ready rises are ignored.
        rd_en = 1'b1; wr_en = 1'b1; rd_addr = 64'd7; wr_addr = 64'd7; wdata = 64'h99;
        do_reset(1);
        step();
        chk("t6_ignored_rd", {32'b0, o_rd_count}, 64'd0);
        chk("t6_ignored_wr", {32'b0, o_wr_count}, 64'd0);
        idle();
        wait_ready();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 299) == 0) do_reset($urandom_range(1, 3));
            rd_en   = $urandom_range(0, 1);
            wr_en   = $urandom_range(0, 1);
            rd_addr = rand_addr();
            wr_addr = ($urandom_range(0, 3) == 0) ? rd_addr : rand_addr();
            wdata   = {$urandom, $urandom};
            step();
        end
        idle();
        wait_ready();

        // Saturation: preload both counters just below the ceiling.
        force dut.rd_cnt_q = 32'hFFFF_FFFE;
        force dut.wr_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.rd_cnt_q;
        release dut.wr_cnt_q;
        #1;
        forced = (dut.rd_cnt_q == 32'hFFFF_FFFE) && (dut.wr_cnt_q == 32'hFFFF_FFFE);
        if (forced) begin
            m_rd = 64'hFFFF_FFFE;
            m_wr = 64'hFFFF_FFFE;
        end else begin
            $display("note: counter preload did not take effect, saturation literals skipped");
        end
        rd_en = 1'b1; wr_en = 1'b1; rd_addr = 64'd2; wr_addr = 64'd3; wdata = 64'h1;
        repeat (3) step();
        idle();
        if (forced) begin
            chk("sat_rd_count", {32'b0, o_rd_count}, 64'hFFFF_FFFF);
            chk("sat_wr_count", {32'b0, o_wr_count}, 64'hFFFF_FFFF);
        end
        repeat (LAT + 2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
